// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FMADD control path: operand field geometry,
// multiplier wait limit, underflow threshold and the sequencer state type.
// No ports; imported by fmadd_sequencer and fmadd_wait_counter.
// ---------------------------------------------------------------------------
package fpu_pkg;

   localparam int FPU_STD          = 31;
   localparam int FPU_MAN          = 22;
   localparam int FPU_EXP          = 7;
   localparam int FPU_MUL_TIMEOUT  = 15;
   localparam int FPU_UFLOW_THRESH = 103;
   localparam int FPU_WAIT_W       = 4;

   // State literals carry an S_ prefix so they never collide with the
   // EXP field-width parameter of the sequencer.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EXP  = 3'd1,
      S_MUL  = 3'd2,
      S_ADD  = 3'd3,
      S_NORM = 3'd4,
      S_RND  = 3'd5,
      S_RESP = 3'd6
   } fmadd_state_t;

endpackage

// File: rtl/fmadd_wait_counter.sv
// ---------------------------------------------------------------------------
// fmadd_wait_counter
// Counts the cycles the sequencer has spent waiting for the multiplier.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear (has priority over enable)
//   enable    - count one more waiting cycle
//   tc        - terminal count: this enabled cycle is the TERMINAL-th one
// ---------------------------------------------------------------------------
module fmadd_wait_counter
   import fpu_pkg::*;
#(
   parameter int TERMINAL = FPU_MUL_TIMEOUT
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [FPU_WAIT_W-1:0] LAST = FPU_WAIT_W'(TERMINAL - 1);

   logic [FPU_WAIT_W-1:0] count;

   // The count is 0 on the first waiting cycle, so the counter reaches
   // TERMINAL exactly when the TERMINAL-th waiting cycle completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Terminal count looks one step ahead so the owner can leave its wait
   // state on the same edge at which the count reaches TERMINAL.
   assign tc = enable && (count == LAST);

endmodule

// File: rtl/fmadd_sequencer.sv
// ---------------------------------------------------------------------------
// fmadd_sequencer
// Control sequencer for a fused multiply-add a*b+c. Walks an operand set
// through exponent add, multiply, add, normalise and round, then holds the
// result phase until the consumer accepts it.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid / in_ready      - operand handshake (ready only when idle)
//   op_a, op_b, op_c         - operands
//   exp_add_act, exp_a/exp_b - exponent adder start and {sign,exponent} fields
//   exp_sum_i, exp_sign_i,
//   uflow_i                  - exponent adder results
//   mul_act / mul_done_i     - multiplier start / finished
//   add_act, norm_act,
//   rnd_act                  - later stage activations
//   out_valid / out_ready    - result handshake
//   busy                     - sequencer not idle
//   uflow_o, zero_byp_o,
//   timeout_o                - status flags for the current operation
//   prod_exp_o, prod_sign_o  - latched exponent sum and product sign
// ---------------------------------------------------------------------------
module fmadd_sequencer
   import fpu_pkg::*;
#(
   parameter int STD         = FPU_STD,
   parameter int MAN         = FPU_MAN,
   parameter int EXP         = FPU_EXP,
   parameter int MUL_TIMEOUT = FPU_MUL_TIMEOUT
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [STD:0]   op_a,
   input  logic [STD:0]   op_b,
   input  logic [STD:0]   op_c,
   output logic           exp_add_act,
   output logic [EXP+1:0] exp_a,
   output logic [EXP+1:0] exp_b,
   input  logic [EXP+1:0] exp_sum_i,
   input  logic           exp_sign_i,
   input  logic           uflow_i,
   output logic           mul_act,
   input  logic           mul_done_i,
   output logic           add_act,
   output logic           norm_act,
   output logic           rnd_act,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy,
   output logic           uflow_o,
   output logic           zero_byp_o,
   output logic           timeout_o,
   output logic [EXP+1:0] prod_exp_o,
   output logic           prod_sign_o
);

   fmadd_state_t state;
   logic         wait_tc;
   logic         a_exp_zero;
   logic         b_exp_zero;

   // The captured {sign,exponent} fields of a and b live in the exp_a/exp_b
   // registers for the one EXP cycle, which is the only cycle the zero
   // bypass decision needs them. The addend and mantissas are consumed by
   // the datapath, not by this sequencer.
   assign a_exp_zero = (exp_a[EXP:0] == '0);
   assign b_exp_zero = (exp_b[EXP:0] == '0);

   // The wait counter runs only while in MUL and is held cleared in every
   // other state, so each MUL visit starts counting from zero.
   fmadd_wait_counter #(
      .TERMINAL (MUL_TIMEOUT)
   ) u_wait_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (state != S_MUL),
      .enable (state == S_MUL),
      .tc     (wait_tc)
   );

   // Handshake and status outputs are pure decodes of the state register.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

   // Main sequencer. Every activation output is registered and set on the
   // edge that enters its state, so each one is high for exactly the cycle
   // its stage runs and they can never overlap. mul_act is only raised on
   // the EXP->MUL edge, which makes it a single first-cycle pulse. Flags
   // are cleared on a new handshake and otherwise hold, which keeps them
   // stable through RESP and readable while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         exp_add_act <= 1'b0;
         mul_act     <= 1'b0;
         add_act     <= 1'b0;
         norm_act    <= 1'b0;
         rnd_act     <= 1'b0;
         exp_a       <= '0;
         exp_b       <= '0;
         uflow_o     <= 1'b0;
         zero_byp_o  <= 1'b0;
         timeout_o   <= 1'b0;
         prod_exp_o  <= '0;
         prod_sign_o <= 1'b0;
      end else begin
         exp_add_act <= 1'b0;
         mul_act     <= 1'b0;
         add_act     <= 1'b0;
         norm_act    <= 1'b0;
         rnd_act     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  state       <= S_EXP;
                  exp_add_act <= 1'b1;
                  exp_a       <= op_a[STD:MAN+1];
                  exp_b       <= op_b[STD:MAN+1];
                  uflow_o     <= 1'b0;
                  zero_byp_o  <= 1'b0;
                  timeout_o   <= 1'b0;
               end
            end
            S_EXP: begin
               exp_a       <= '0;
               exp_b       <= '0;
               prod_exp_o  <= exp_sum_i;
               prod_sign_o <= exp_sign_i;
               if (a_exp_zero || b_exp_zero) begin
                  state      <= S_ADD;
                  add_act    <= 1'b1;
                  zero_byp_o <= 1'b1;
                  uflow_o    <= 1'b0;
               end else begin
                  state   <= S_MUL;
                  mul_act <= 1'b1;
                  uflow_o <= uflow_i;
               end
            end
            S_MUL: begin
               if (mul_done_i) begin
                  state   <= S_ADD;
                  add_act <= 1'b1;
               end else if (wait_tc) begin
                  state     <= S_RESP;
                  timeout_o <= 1'b1;
               end
            end
            S_ADD: begin
               state    <= S_NORM;
               norm_act <= 1'b1;
            end
            S_NORM: begin
               state   <= S_RND;
               rnd_act <= 1'b1;
            end
            S_RND: begin
               state <= S_RESP;
            end
            S_RESP: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fmadd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fmadd_sequencer
// Self-checking bench for fmadd_sequencer. The bench plays the exponent
// adder and the multiplier, and keeps a transaction-level model that knows,
// for each cycle after a handshake, which stage must be active and what the
// flags must read. Multiplier delay N means mul_done_i is raised on the
// N-th MUL cycle, counting the mul_act cycle as the first (N=0: never).
// ---------------------------------------------------------------------------
module tb_fmadd_sequencer;

   localparam int T = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] op_c = '0;
   logic        exp_add_act;
   logic [8:0]  exp_a;
   logic [8:0]  exp_b;
   logic [8:0]  exp_sum_i;
   logic        exp_sign_i;
   logic        uflow_i;
   logic        mul_act;
   logic        mul_done_i = 1'b0;
   logic        add_act;
   logic        norm_act;
   logic        rnd_act;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        uflow_o;
   logic        zero_byp_o;
   logic        timeout_o;
   logic [8:0]  prod_exp_o;
   logic        prod_sign_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int mul_delay = 0;
   int mul_cnt = 0;

   // model state for the transaction in flight
   bit          active = 1'b0;
   int          d = 0;
   int          resp_start = 0;
   bit          m_bypass, m_to;
   logic [8:0]  m_ea, m_eb, t_pe;
   logic        t_ps, t_uf;
   logic [8:0]  h_pe = '0;
   logic        h_ps = 1'b0, h_zb = 1'b0, h_uf = 1'b0, h_to = 1'b0;
   int          hs_cyc = 0, last_lat = -1;
   int          obs_mul = 0, obs_add = 0, obs_norm = 0, obs_rnd = 0;

   // expected outputs for the current cycle
   logic [8:0]  e_ea, e_eb, e_pe;
   logic        e_ps, e_zb, e_uf, e_to, e_exp, e_mul, e_add, e_norm, e_rnd;
   logic        e_ov, e_busy;

   always #5 clk = ~clk;

   fmadd_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_c        (op_c),
      .exp_add_act (exp_add_act),
      .exp_a       (exp_a),
      .exp_b       (exp_b),
      .exp_sum_i   (exp_sum_i),
      .exp_sign_i  (exp_sign_i),
      .uflow_i     (uflow_i),
      .mul_act     (mul_act),
      .mul_done_i  (mul_done_i),
      .add_act     (add_act),
      .norm_act    (norm_act),
      .rnd_act     (rnd_act),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .uflow_o     (uflow_o),
      .zero_byp_o  (zero_byp_o),
      .timeout_o   (timeout_o),
      .prod_exp_o  (prod_exp_o),
      .prod_sign_o (prod_sign_o)
   );

   // Exponent adder stand-in: biased sum, product sign, underflow on raw sum.
   always_comb begin
      exp_sum_i  = 9'({1'b0, exp_a[7:0]} + {1'b0, exp_b[7:0]} - 9'd127);
      exp_sign_i = exp_a[8] ^ exp_b[8];
      uflow_i    = ({1'b0, exp_a[7:0]} + {1'b0, exp_b[7:0]}) < 9'd103;
   end

   // Multiplier stand-in: answers on the mul_delay-th MUL cycle.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         mul_done_i = 1'b0;
         mul_cnt    = 0;
      end else if (mul_act) begin
         mul_done_i = (mul_delay == 1);
         mul_cnt    = (mul_delay > 1) ? mul_delay - 1 : 0;
      end else if (mul_cnt > 0) begin
         mul_cnt    = mul_cnt - 1;
         mul_done_i = (mul_cnt == 0);
      end else begin
         mul_done_i = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Per-cycle compare against the transaction model, then model advance.
   always @(negedge clk) begin
      cyc++;
      e_ea = '0; e_eb = '0; e_exp = 0; e_mul = 0; e_add = 0; e_norm = 0; e_rnd = 0;
      e_ov = 0; e_busy = 0;
      e_pe = h_pe; e_ps = h_ps; e_zb = h_zb; e_uf = h_uf; e_to = h_to;
      if (rst) begin
         active = 0;
         h_pe = '0; h_ps = 0; h_zb = 0; h_uf = 0; h_to = 0;
         e_pe = '0; e_ps = 0; e_zb = 0; e_uf = 0; e_to = 0;
      end else if (active) begin
         e_busy = 1;
         if (d == 1) begin
            e_exp = 1; e_ea = m_ea; e_eb = m_eb;
            e_zb = 0; e_uf = 0; e_to = 0;
         end else begin
            e_zb = m_bypass; e_uf = t_uf; e_to = m_to && (d >= resp_start);
            e_pe = t_pe; e_ps = t_ps;
         end
         e_mul  = !m_bypass && (d == 2);
         e_add  = !m_to && (d == resp_start - 3);
         e_norm = !m_to && (d == resp_start - 2);
         e_rnd  = !m_to && (d == resp_start - 1);
         e_ov   = (d >= resp_start);
      end
      checkOutput("in_ready",    32'(in_ready),    32'(!e_busy));
      checkOutput("busy",        32'(busy),        32'(e_busy));
      checkOutput("out_valid",   32'(out_valid),   32'(e_ov));
      checkOutput("exp_add_act", 32'(exp_add_act), 32'(e_exp));
      checkOutput("mul_act",     32'(mul_act),     32'(e_mul));
      checkOutput("add_act",     32'(add_act),     32'(e_add));
      checkOutput("norm_act",    32'(norm_act),    32'(e_norm));
      checkOutput("rnd_act",     32'(rnd_act),     32'(e_rnd));
      checkOutput("exp_a",       32'(exp_a),       32'(e_ea));
      checkOutput("exp_b",       32'(exp_b),       32'(e_eb));
      checkOutput("prod_exp_o",  32'(prod_exp_o),  32'(e_pe));
      checkOutput("prod_sign_o", 32'(prod_sign_o), 32'(e_ps));
      checkOutput("uflow_o",     32'(uflow_o),     32'(e_uf));
      checkOutput("zero_byp_o",  32'(zero_byp_o),  32'(e_zb));
      checkOutput("timeout_o",   32'(timeout_o),   32'(e_to));
      if (!rst && active) begin
         if (mul_act)  obs_mul++;
         if (add_act)  obs_add++;
         if (norm_act) obs_norm++;
         if (rnd_act)  obs_rnd++;
         if (out_valid && last_lat < 0) last_lat = cyc - hs_cyc;
      end
      if (!rst) begin
         if (!active) begin
            if (in_valid) begin
               active     = 1;
               d          = 1;
               m_ea       = op_a[31:23];
               m_eb       = op_b[31:23];
               m_bypass   = (op_a[30:23] == 8'd0) || (op_b[30:23] == 8'd0);
               m_to       = !m_bypass && (mul_delay == 0 || mul_delay > T);
               resp_start = m_bypass ? 5 : (m_to ? 2 + T : 5 + mul_delay);
               t_pe       = 9'({1'b0, op_a[30:23]} + {1'b0, op_b[30:23]} - 9'd127);
               t_ps       = op_a[31] ^ op_b[31];
               t_uf       = !m_bypass && ((int'(op_a[30:23]) + int'(op_b[30:23])) < 103);
               hs_cyc     = cyc;
               last_lat   = -1;
               obs_mul = 0; obs_add = 0; obs_norm = 0; obs_rnd = 0;
            end
         end else if (d >= resp_start && out_ready) begin
            active = 0;
            h_pe = t_pe; h_ps = t_ps; h_zb = m_bypass; h_uf = t_uf; h_to = m_to;
         end else begin
            d++;
         end
      end
   end

   // One operation: offer, wait for the result (junk on the inputs while
   // busy), hold off acceptance for 'hold' cycles, then accept.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int n, input int hold);
      int waited;
      op_a = a; op_b = b; op_c = $urandom; mul_delay = n;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      waited = 0;
      while (!out_valid && waited < 40) begin
         in_valid = 1'($urandom_range(0, 1));
         op_a = $urandom; op_b = $urandom; op_c = $urandom;
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("resp_reached", 32'(out_valid), 32'd1);
      repeat (hold) begin
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] ra, rb;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_prod_exp", 32'(prod_exp_o), 32'd0);

      // 1.0 * 2.0, multiplier answers on its 3rd cycle
      applyStimulus(32'h3F800000, 32'h40000000, 3, 0);
      checkOutput("normal_latency", 32'(last_lat), 32'd8);
      checkOutput("normal_prod_exp", 32'(prod_exp_o), 32'h080);
      checkOutput("normal_uflow", 32'(uflow_o), 32'd0);
      checkOutput("normal_mul_pulses", 32'(obs_mul), 32'd1);

      // zero exponent on a takes the bypass
      applyStimulus(32'h00000000, 32'h40400000, 2, 0);
      checkOutput("bypass_latency", 32'(last_lat), 32'd5);
      checkOutput("bypass_flag", 32'(zero_byp_o), 32'd1);
      checkOutput("bypass_no_mul", 32'(obs_mul), 32'd0);

      // tiny exponents underflow; result held off for 10 cycles
      applyStimulus(32'h00800000, 32'h80800000, 2, 10);
      checkOutput("uflow_flag", 32'(uflow_o), 32'd1);
      checkOutput("uflow_sign", 32'(prod_sign_o), 32'd1);
      checkOutput("uflow_latency", 32'(last_lat), 32'd7);

      // multiplier never answers
      applyStimulus(32'h3F800000, 32'h40000000, 0, 2);
      checkOutput("timeout_latency", 32'(last_lat), 32'(2 + T));
      checkOutput("timeout_flag", 32'(timeout_o), 32'd1);
      checkOutput("timeout_no_stages", 32'(obs_add + obs_norm + obs_rnd), 32'd0);

      // answer on the terminal cycle wins over the timeout
      applyStimulus(32'h3F800000, 32'h40000000, T, 0);
      checkOutput("terminal_latency", 32'(last_lat), 32'(5 + T));
      checkOutput("terminal_timeout", 32'(timeout_o), 32'd0);
      checkOutput("terminal_rnd", 32'(obs_rnd), 32'd1);

      // reset in the middle of MUL aborts the operation
      op_a = 32'h3F800000; op_b = 32'h40000000; mul_delay = 0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_acts", 32'({exp_add_act, mul_act, add_act, norm_act, rnd_act, out_valid, busy}), 32'd0);
      checkOutput("rst_flags", 32'({uflow_o, zero_byp_o, timeout_o, prod_sign_o}), 32'd0);
      checkOutput("rst_prod_exp", 32'(prod_exp_o), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      applyStimulus(32'h3F800000, 32'h40000000, 3, 1);
      checkOutput("post_rst_latency", 32'(last_lat), 32'd8);
      checkOutput("post_rst_prod_exp", 32'(prod_exp_o), 32'h080);

      // random operations
      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 4) == 0) ra[30:23] = 8'd0;
         if ($urandom_range(0, 4) == 0) rb[30:23] = 8'd0;
         if ($urandom_range(0, 3) == 0) ra[30:23] = 8'($urandom_range(1, 60));
         applyStimulus(ra, rb, int'($urandom_range(0, 17)), int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
